vga_timing_gen: RTL and testbench

Source of the packed VGA bus consumed by every drawing stage (title screen, background, character overlay, track/car renderers). Free-running horizontal and vertical counters produce the 800x600@60 Hz (40 MHz pixel clock) timing and emit it as the `VGA_BUS_SIZE` (38-bit) bus with registered, mutually aligned fields. The rgb field leaves this block as black, or as a colour-bar test pattern when built with the configuration macro.

---
 rtl/vga_timing_gen_if.sv | 13 +
 rtl/vga_timing_gen.sv | 100 ++++++++++
 tb/tb_vga_timing_gen.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Packed VGA bus (hcount/hsync/hblnk/vcount/vsync/vblnk/rgb) plus frame marker,
// driven by vga_timing_gen and consumed by the drawing stages.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

interface vga_timing_gen_if;
  logic [`VGA_BUS_SIZE-1:0] vga_out;
  logic                     frame_start;

  modport master (output vga_out, output frame_start);
  modport slave  (input vga_out, input frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// 800x600@60 timing source: free-running h/v counters with zero-skew registered flags.
// Define VGA_TEST_PATTERN_EN to drive 8 vertical colour bars instead of black.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE     = 800,
  parameter int unsigned H_SYNC_START = 840,
  parameter int unsigned H_SYNC_END   = 968,
  parameter int unsigned H_TOTAL      = 1056,
  parameter int unsigned V_ACTIVE     = 600,
  parameter int unsigned V_SYNC_START = 601,
  parameter int unsigned V_SYNC_END   = 605,
  parameter int unsigned V_TOTAL      = 628
) (
  input logic              pclk,
  input logic              rst,
  vga_timing_gen_if.master vga
);

  // 12-bit compare constants so SYNC_END/TOTAL of 2048 still compare correctly
  localparam logic [11:0] H_ACT = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS  = 12'(H_SYNC_START);
  localparam logic [11:0] H_SE  = 12'(H_SYNC_END);
  localparam logic [11:0] H_TOT = 12'(H_TOTAL);
  localparam logic [11:0] V_ACT = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS  = 12'(V_SYNC_START);
  localparam logic [11:0] V_SE  = 12'(V_SYNC_END);
  localparam logic [11:0] V_TOT = 12'(V_TOTAL);

  logic [10:0] hcount, vcount;
  logic        hsync, hblnk, vsync, vblnk, frame_start;
  logic [11:0] rgb;

  logic [10:0] h_next, v_next;
  logic        h_wrap;
  logic        hsync_next, hblnk_next, vsync_next, vblnk_next;
  logic [11:0] rgb_next;

  // Wrap with >= so a corrupted counter returns to 0 instead of running on
  always_comb begin
    h_wrap = ({1'b0, hcount} >= H_TOT - 12'd1);
    h_next = h_wrap ? 11'd0 : hcount + 11'd1;
    v_next = vcount;
    if ({1'b0, vcount} >= V_TOT) begin
      v_next = 11'd0;
    end else if (h_wrap) begin
      v_next = ({1'b0, vcount} >= V_TOT - 12'd1) ? 11'd0 : vcount + 11'd1;
    end
  end

  always_comb begin
    hblnk_next = ({1'b0, h_next} >= H_ACT);
    hsync_next = ({1'b0, h_next} >= H_SS) && ({1'b0, h_next} < H_SE);
    vblnk_next = ({1'b0, v_next} >= V_ACT);
    vsync_next = ({1'b0, v_next} >= V_SS) && ({1'b0, v_next} < V_SE);
  end

`ifdef VGA_TEST_PATTERN_EN
  always_comb begin
    rgb_next = 12'h000;
    if (!hblnk_next && !vblnk_next) begin
      if      (h_next < 11'd100) rgb_next = 12'h000;
      else if (h_next < 11'd200) rgb_next = 12'hF00;
      else if (h_next < 11'd300) rgb_next = 12'h0F0;
      else if (h_next < 11'd400) rgb_next = 12'h00F;
      else if (h_next < 11'd500) rgb_next = 12'hFF0;
      else if (h_next < 11'd600) rgb_next = 12'h0FF;
      else if (h_next < 11'd700) rgb_next = 12'hF0F;
      else                       rgb_next = 12'hFFF;
    end
  end
`else
  assign rgb_next = 12'h000;
`endif

  // All bus fields share one flop stage so they always describe the same pixel
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hsync       <= 1'b0;
      hblnk       <= 1'b0;
      vsync       <= 1'b0;
      vblnk       <= 1'b0;
      rgb         <= 12'h000;
      frame_start <= 1'b1;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      hsync       <= hsync_next;
      hblnk       <= hblnk_next;
      vsync       <= vsync_next;
      vblnk       <= vblnk_next;
      rgb         <= rgb_next;
      frame_start <= (h_next == 11'd0) && (v_next == 11'd0);
    end
  end

  assign vga.vga_out     = {hcount, hsync, hblnk, vcount, vsync, vblnk, rgb};
  assign vga.frame_start = frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: per-cycle comparison against a pixel-index model plus
// directed literal checks. Vertical timing is shortened so several frames fit.
module tb_vga_timing_gen;

  localparam int unsigned H_ACTIVE     = 800;
  localparam int unsigned H_SYNC_START = 840;
  localparam int unsigned H_SYNC_END   = 968;
  localparam int unsigned H_TOTAL      = 1056;
  localparam int unsigned V_ACTIVE     = 6;
  localparam int unsigned V_SYNC_START = 7;
  localparam int unsigned V_SYNC_END   = 9;
  localparam int unsigned V_TOTAL      = 12;
  localparam int unsigned FRAME        = H_TOTAL * V_TOTAL;

  bit pclk = 1'b0;
  bit rst  = 1'b1;

  vga_timing_gen_if bus ();

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_SYNC_START(H_SYNC_START), .H_SYNC_END(H_SYNC_END), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_SYNC_START(V_SYNC_START), .V_SYNC_END(V_SYNC_END), .V_TOTAL(V_TOTAL)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .vga (bus)
  );

  always #5 pclk = ~pclk;

  int vectors     = 0;
  int miscompares = 0;
  int cycle_fail_prints = 0;

  int unsigned pix_index = 0;
  bit          model_valid = 1'b0;

`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] bar_colour [8] = '{12'h000, 12'hF00, 12'h0F0, 12'h00F,
                                  12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF};
`endif

  // Position within the frame is simply the number of edges since reset
  function automatic logic [38:0] model_out(input int unsigned p);
    int unsigned h, v;
    logic [11:0] colour;
    h = p % H_TOTAL;
    v = (p / H_TOTAL) % V_TOTAL;
    colour = 12'h000;
`ifdef VGA_TEST_PATTERN_EN
    if (h < H_ACTIVE && v < V_ACTIVE) colour = bar_colour[h / 100];
`endif
    return {11'(h), (h >= H_SYNC_START && h < H_SYNC_END), (h >= H_ACTIVE),
            11'(v), (v >= V_SYNC_START && v < V_SYNC_END), (v >= V_ACTIVE),
            colour, (p == 0)};
  endfunction

  always @(posedge pclk) begin
    if (rst) begin
      pix_index   = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      pix_index = (pix_index + 1) % FRAME;
    end
  end

  always @(negedge pclk) begin
    logic [38:0] expected;
    if (model_valid) begin
      expected = model_out(pix_index);
      vectors++;
      if ({bus.vga_out, bus.frame_start} !== expected) begin
        miscompares++;
        if (cycle_fail_prints < 20) begin
          cycle_fail_prints++;
          $display("[TB] FAIL per_cycle index=%0d actual=%h expected=%h",
                   pix_index, {bus.vga_out, bus.frame_start}, expected);
        end
      end
    end
  end

  task automatic apply_stimulus(input bit rst_val, input int unsigned cycles);
    rst = rst_val;
    repeat (cycles) @(negedge pclk);
  endtask

  task automatic check_output(input string name, input logic [37:0] actual, input logic [37:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  initial begin
    int unsigned pulses;
    int unsigned last_pulse;

    // Reset and release
    apply_stimulus(1'b1, 2);
    check_output("reset_bus", bus.vga_out, 38'h0);
    check_output("reset_frame_start", 38'(bus.frame_start), 38'd1);
    apply_stimulus(1'b0, 1);
    check_output("release_hcount", 38'(bus.vga_out[37:27]), 38'd1);
    check_output("release_vcount", 38'(bus.vga_out[24:14]), 38'd0);
    check_output("release_frame_start", 38'(bus.frame_start), 38'd0);

    // Horizontal windows
    apply_stimulus(1'b0, 798);
    check_output("h799_hcount", 38'(bus.vga_out[37:27]), 38'd799);
    check_output("h799_hblnk", 38'(bus.vga_out[25]), 38'd0);
`ifdef VGA_TEST_PATTERN_EN
    check_output("h799_rgb", 38'(bus.vga_out[11:0]), 38'hFFF);
`else
    check_output("h799_rgb", 38'(bus.vga_out[11:0]), 38'h000);
`endif
    apply_stimulus(1'b0, 1);
    check_output("h800_hblnk", 38'(bus.vga_out[25]), 38'd1);
    check_output("h800_rgb", 38'(bus.vga_out[11:0]), 38'h000);
    apply_stimulus(1'b0, 39);
    check_output("h839_hsync", 38'(bus.vga_out[26]), 38'd0);
    apply_stimulus(1'b0, 1);
    check_output("h840_hsync", 38'(bus.vga_out[26]), 38'd1);
    apply_stimulus(1'b0, 127);
    check_output("h967_hsync", 38'(bus.vga_out[26]), 38'd1);
    apply_stimulus(1'b0, 1);
    check_output("h968_hsync", 38'(bus.vga_out[26]), 38'd0);
    apply_stimulus(1'b0, 87);
    check_output("h1055_hcount", 38'(bus.vga_out[37:27]), 38'd1055);
    check_output("h1055_vcount", 38'(bus.vga_out[24:14]), 38'd0);
    apply_stimulus(1'b0, 1);
    check_output("line_wrap_hcount", 38'(bus.vga_out[37:27]), 38'd0);
    check_output("line_wrap_vcount", 38'(bus.vga_out[24:14]), 38'd1);
    apply_stimulus(1'b0, 150);
    check_output("h150_hcount", 38'(bus.vga_out[37:27]), 38'd150);
`ifdef VGA_TEST_PATTERN_EN
    check_output("h150_rgb", 38'(bus.vga_out[11:0]), 38'hF00);
`else
    check_output("h150_rgb", 38'(bus.vga_out[11:0]), 38'h000);
`endif

    // Vertical windows
    apply_stimulus(1'b0, 5130);
    check_output("v6_vcount", 38'(bus.vga_out[24:14]), 38'd6);
    check_output("v6_vblnk", 38'(bus.vga_out[12]), 38'd1);
    check_output("v6_vsync", 38'(bus.vga_out[13]), 38'd0);
    check_output("v6_rgb", 38'(bus.vga_out[11:0]), 38'h000);
    apply_stimulus(1'b0, 1056);
    check_output("v7_vsync", 38'(bus.vga_out[13]), 38'd1);
    apply_stimulus(1'b0, 2111);
    check_output("v8_end_vsync", 38'(bus.vga_out[13]), 38'd1);
    apply_stimulus(1'b0, 1);
    check_output("v9_vsync", 38'(bus.vga_out[13]), 38'd0);
    check_output("v9_vblnk", 38'(bus.vga_out[12]), 38'd1);
    apply_stimulus(1'b0, 3167);
    check_output("frame_end_pos", 38'({bus.vga_out[37:27], bus.vga_out[24:14]}), 38'({11'd1055, 11'd11}));
    apply_stimulus(1'b0, 1);
    check_output("frame_wrap_pos", 38'({bus.vga_out[37:27], bus.vga_out[24:14]}), 38'd0);
    check_output("frame_wrap_vblnk", 38'(bus.vga_out[12]), 38'd0);
    check_output("frame_wrap_frame_start", 38'(bus.frame_start), 38'd1);

    // frame_start spacing over three frames
    pulses = 0;
    last_pulse = 0;
    for (int unsigned i = 1; i <= 3 * FRAME; i++) begin
      apply_stimulus(1'b0, 1);
      if (bus.frame_start) begin
        pulses++;
        check_output("frame_start_gap", 38'(i - last_pulse), 38'(FRAME));
        check_output("frame_start_pos", 38'({bus.vga_out[37:27], bus.vga_out[24:14]}), 38'd0);
        last_pulse = i;
      end
    end
    check_output("frame_start_pulses", 38'(pulses), 38'd3);

    // Reset mid-frame held for three cycles
    apply_stimulus(1'b0, 3 * 1056 + 500);
    check_output("mid_hcount", 38'(bus.vga_out[37:27]), 38'd500);
    check_output("mid_vcount", 38'(bus.vga_out[24:14]), 38'd3);
    apply_stimulus(1'b1, 1);
    check_output("mid_reset_bus", bus.vga_out, 38'h0);
    check_output("mid_reset_frame_start", 38'(bus.frame_start), 38'd1);
    apply_stimulus(1'b1, 2);
    check_output("mid_reset_held_bus", bus.vga_out, 38'h0);
    apply_stimulus(1'b0, 1);
    check_output("mid_release_hcount", 38'(bus.vga_out[37:27]), 38'd1);
    check_output("mid_release_frame_start", 38'(bus.frame_start), 38'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
